lcd_frame_writer: RTL and testbench



---
 rtl/lcd_pkg.sv | 65 ++++++
 rtl/lcd_byte_xfer.sv | 132 +++++++++++++
 rtl/lcd_frame_writer_chk.sv | 24 ++
 rtl/lcd_frame_writer.sv | 204 ++++++++++++++++++++
 tb/tb_lcd_frame_writer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780 frame writer.
//   - controller command bytes used by the init and frame sequences
//   - top-level and byte-engine state encodings
//   - sequence lengths and byte-selection helpers
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off, blink off
  localparam logic [7:0] LCD_CLEAR    = 8'h01;  // clear display (long execution time)
  localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment address, no shift
  localparam logic [7:0] LCD_ROW1     = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] LCD_ROW2     = 8'hC0;  // DDRAM address 0x40

  localparam logic [5:0] INIT_LEN  = 6'd4;
  localparam logic [5:0] FRAME_LEN = 6'd34;

  typedef enum logic [1:0] {
    ST_PWRUP = 2'd0,
    ST_INIT  = 2'd1,
    ST_IDLE  = 2'd2,
    ST_FRAME = 2'd3
  } lcd_state_e;

  typedef enum logic [1:0] {
    XF_IDLE  = 2'd0,
    XF_SETUP = 2'd1,
    XF_PULSE = 2'd2,
    XF_WAIT  = 2'd3
  } xfer_state_e;

  // Power-up command sequence, indexed by position.
  function automatic logic [7:0] init_cmd(input logic [5:0] idx);
    logic [7:0] cmd;
    case (idx)
      6'd0:    cmd = LCD_FUNC_SET;
      6'd1:    cmd = LCD_DISP_ON;
      6'd2:    cmd = LCD_CLEAR;
      6'd3:    cmd = LCD_ENTRY;
      default: cmd = 8'h00;
    endcase
    return cmd;
  endfunction

  // Character k of a 32-character frame lives at bits [8k +: 8].
  function automatic logic [7:0] char_at(input logic [255:0] f, input logic [4:0] k);
    return f[{k, 3'b000} +: 8];
  endfunction

  // Byte number idx of a frame write, returned as {rs, data}.
  // 0: row-1 address, 1..16: chars 0..15, 17: row-2 address, 18..33: chars 16..31.
  function automatic logic [8:0] frame_byte(input logic [255:0] f, input logic [5:0] idx);
    logic [8:0] b;
    if (idx == 6'd0) begin
      b = {1'b0, LCD_ROW1};
    end else if (idx <= 6'd16) begin
      b = {1'b1, char_at(f, 5'(idx - 6'd1))};
    end else if (idx == 6'd17) begin
      b = {1'b0, LCD_ROW2};
    end else begin
      b = {1'b1, char_at(f, 5'(idx - 6'd2))};
    end
    return b;
  endfunction

endpackage

// File: rtl/lcd_byte_xfer.sv
// lcd_byte_xfer: single-byte write engine for the HD44780 parallel bus.
// A write runs setup (EN low), pulse (EN high) and wait (EN low) phases
// with RS/DATA held for all three.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_start             : launch a write (taken only while o_ready)
//   i_rs, i_data        : register select and byte for the write
//   i_long_wait         : use T_CLR instead of T_WAIT for the wait phase
//   o_ready             : engine idle, or in the final wait cycle
//   o_lcd_rs/data/en    : registered bus outputs
module lcd_byte_xfer
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP = 4,
  parameter int unsigned T_EN    = 25,
  parameter int unsigned T_WAIT  = 2000,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  input  logic       i_long_wait,
  output logic       o_ready,
  output logic       o_lcd_rs,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_en
);

  localparam int unsigned T_MAX_A = (T_SETUP > T_EN) ? T_SETUP : T_EN;
  localparam int unsigned T_MAX_B = (T_WAIT > T_CLR) ? T_WAIT : T_CLR;
  localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned CW      = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] EN_LAST    = CW'(T_EN - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(T_WAIT - 1);
  localparam logic [CW-1:0] CLR_LAST   = CW'(T_CLR - 1);

  xfer_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          long_q, long_d;
  logic          en_q, en_d;
  logic [CW-1:0] wait_last;
  logic          ready;

  // Phase sequencing. Ready is raised in the last wait cycle as well, so a
  // follow-on byte starts its setup with no idle gap in between.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rs_d      = rs_q;
    data_d    = data_q;
    long_d    = long_q;
    wait_last = long_q ? CLR_LAST : WAIT_LAST;
    ready     = (state_q == XF_IDLE) ||
                ((state_q == XF_WAIT) && (cnt_q == wait_last));

    if (ready && i_start) begin
      state_d = XF_SETUP;
      cnt_d   = '0;
      rs_d    = i_rs;
      data_d  = i_data;
      long_d  = i_long_wait;
    end else begin
      case (state_q)
        XF_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            state_d = XF_PULSE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        XF_PULSE: begin
          if (cnt_q == EN_LAST) begin
            state_d = XF_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        XF_WAIT: begin
          if (cnt_q == wait_last) begin
            state_d = XF_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        XF_IDLE: begin
          cnt_d = '0;
        end
        default: begin
          state_d = XF_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // EN is registered from the next state so it lines up with the phase.
    en_d = (state_d == XF_PULSE);
  end

  // Engine state, counter and bus registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= XF_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      long_q  <= long_d;
      en_q    <= en_d;
    end
  end

  assign o_ready    = ready;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_data = data_q;
  assign o_lcd_en   = en_q;

endmodule

// File: rtl/lcd_frame_writer_chk.sv
// lcd_frame_writer_chk: simulation-only sanity checks on the timing
// parameters. Every phase must last at least one cycle.
// Ports:
//   i_clk : system clock the checks are evaluated on
module lcd_frame_writer_chk #(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_SETUP   = 4,
  parameter int unsigned T_EN      = 25,
  parameter int unsigned T_WAIT    = 2000,
  parameter int unsigned T_CLR     = 82000
) (
  input logic i_clk
);

  // Reject zero-length phases.
  always @(posedge i_clk) begin
    assert (T_POWERUP != 0);
    assert (T_SETUP != 0);
    assert (T_EN != 0);
    assert (T_WAIT != 0);
    assert (T_CLR != 0);
  end

endmodule

// File: rtl/lcd_frame_writer.sv
// lcd_frame_writer: writes a 32-character frame to a 16x2 HD44780 LCD.
// Runs the controller power-up init once after reset, then writes frames
// on request with a busy/done handshake. Requests seen while busy are
// collapsed into one pending frame started as soon as the block is free.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_string      : 32 chars, char k at [8k +: 8]; 0..15 row 1, 16..31 row 2
//   i_update      : frame write request
//   o_busy        : high whenever not idle
//   o_done        : one-cycle pulse when a frame write completes
//   LCD_DATA/RS/RW/EN/ON/BLON : LCD parallel bus and power controls
module lcd_frame_writer
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_SETUP   = 4,
  parameter int unsigned T_EN      = 25,
  parameter int unsigned T_WAIT    = 2000,
  parameter int unsigned T_CLR     = 82000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [255:0] i_string,
  input  logic         i_update,
  output logic         o_busy,
  output logic         o_done,
  output logic [7:0]   LCD_DATA,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic         LCD_EN,
  output logic         LCD_ON,
  output logic         LCD_BLON
);

  localparam int unsigned   PW       = $clog2(T_POWERUP + 1);
  localparam logic [PW-1:0] PWR_LAST = PW'(T_POWERUP - 1);

  lcd_state_e    state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [5:0]    idx_q, idx_d;
  logic [255:0]  frame_q, frame_d;
  logic          pending_q, pending_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          launch;
  logic          req;
  logic [8:0]    fbyte;
  logic          x_start;
  logic          x_rs;
  logic [7:0]    x_data;
  logic          x_long;
  logic          x_ready;

  // Sequencer: picks the next byte for the engine and handles the handshake.
  // A byte is issued whenever the engine is ready; idx counts bytes issued.
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    pending_d = pending_q | (i_update & busy_q);
    done_d    = 1'b0;
    launch    = 1'b0;
    req       = pending_q | i_update;
    fbyte     = frame_byte(frame_q, idx_q);
    x_start   = 1'b0;
    x_rs      = 1'b0;
    x_data    = 8'h00;
    x_long    = 1'b0;

    case (state_q)
      ST_PWRUP: begin
        if (pcnt_q == PWR_LAST) begin
          state_d = ST_INIT;
          pcnt_d  = '0;
          x_start = 1'b1;
          x_data  = init_cmd(6'd0);
          idx_d   = 6'd1;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      ST_INIT: begin
        if (!x_ready) begin
          idx_d = idx_q;
        end else if (idx_q == INIT_LEN) begin
          if (req) begin
            launch = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          x_start = 1'b1;
          x_data  = init_cmd(idx_q);
          x_long  = (init_cmd(idx_q) == LCD_CLEAR);
          idx_d   = idx_q + 6'd1;
        end
      end
      ST_IDLE: begin
        if (i_update) begin
          launch = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FRAME: begin
        if (!x_ready) begin
          idx_d = idx_q;
        end else if (idx_q == FRAME_LEN) begin
          done_d = 1'b1;
          if (req) begin
            launch = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          x_start = 1'b1;
          x_rs    = fbyte[8];
          x_data  = fbyte[7:0];
          idx_d   = idx_q + 6'd1;
        end
      end
      default: begin
        state_d = ST_PWRUP;
        pcnt_d  = '0;
        idx_d   = 6'd0;
      end
    endcase

    // Frame start: latch the string and issue the row-1 address in the same
    // cycle, so setup of 0x80 begins the cycle after acceptance.
    if (launch) begin
      state_d   = ST_FRAME;
      frame_d   = i_string;
      idx_d     = 6'd1;
      pending_d = 1'b0;
      x_start   = 1'b1;
      x_rs      = 1'b0;
      x_data    = LCD_ROW1;
      x_long    = 1'b0;
    end else begin
      frame_d = frame_d;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_PWRUP;
      pcnt_q    <= '0;
      idx_q     <= 6'd0;
      frame_q   <= 256'd0;
      pending_q <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  lcd_byte_xfer #(
    .T_SETUP (T_SETUP),
    .T_EN    (T_EN),
    .T_WAIT  (T_WAIT),
    .T_CLR   (T_CLR)
  ) u_xfer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (x_start),
    .i_rs        (x_rs),
    .i_data      (x_data),
    .i_long_wait (x_long),
    .o_ready     (x_ready),
    .o_lcd_rs    (LCD_RS),
    .o_lcd_data  (LCD_DATA),
    .o_lcd_en    (LCD_EN)
  );

  lcd_frame_writer_chk #(
    .T_POWERUP (T_POWERUP),
    .T_SETUP   (T_SETUP),
    .T_EN      (T_EN),
    .T_WAIT    (T_WAIT),
    .T_CLR     (T_CLR)
  ) u_chk (
    .i_clk (i_clk)
  );

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;

endmodule

// File: tb/tb_lcd_frame_writer.sv
`timescale 1ns/1ps
module tb_lcd_frame_writer;

  localparam int unsigned P_PWR   = 20;
  localparam int unsigned P_SETUP = 2;
  localparam int unsigned P_EN    = 3;
  localparam int unsigned P_WAIT  = 5;
  localparam int unsigned P_CLR   = 10;
  localparam int BYTE_P    = P_SETUP + P_EN + P_WAIT;   // 10
  localparam int LONG_P    = P_SETUP + P_EN + P_CLR;    // 15
  localparam int FRAME_CYC = 34 * BYTE_P;               // 340
  localparam int INIT_END  = P_PWR + 3 * BYTE_P + LONG_P; // first non-init cycle: 65

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         upd = 1'b0;
  logic [255:0] str = '0;
  logic         o_busy, o_done;
  logic [7:0]   LCD_DATA;
  logic         LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON;

  lcd_frame_writer #(
    .T_POWERUP (P_PWR),
    .T_SETUP   (P_SETUP),
    .T_EN      (P_EN),
    .T_WAIT    (P_WAIT),
    .T_CLR     (P_CLR)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_string (str),
    .i_update (upd),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .LCD_DATA (LCD_DATA),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_EN   (LCD_EN),
    .LCD_ON   (LCD_ON),
    .LCD_BLON (LCD_BLON)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;   // cycles since previous EN rise; 0 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   done_seen = 0;
  int   done_exp  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference model: what a frame write must put on the bus.
  function automatic void push_frame(input logic [255:0] s, input int first_gap);
    exp_t e;
    e.rs = 1'b0; e.data = 8'h80; e.gap = first_gap; exp_q.push_back(e);
    for (int k = 0; k < 16; k++) begin
      e.rs = 1'b1; e.data = s[8*k +: 8]; e.gap = BYTE_P; exp_q.push_back(e);
    end
    e.rs = 1'b0; e.data = 8'hC0; e.gap = BYTE_P; exp_q.push_back(e);
    for (int k = 16; k < 32; k++) begin
      e.rs = 1'b1; e.data = s[8*k +: 8]; e.gap = BYTE_P; exp_q.push_back(e);
    end
  endfunction

  function automatic void push_init();
    exp_t e;
    e.rs = 1'b0;
    e.data = 8'h38; e.gap = 0;      exp_q.push_back(e);
    e.data = 8'h0C; e.gap = BYTE_P; exp_q.push_back(e);
    e.data = 8'h01; e.gap = BYTE_P; exp_q.push_back(e);
    e.data = 8'h06; e.gap = LONG_P; exp_q.push_back(e);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // Monitor: pops an expectation on every EN rising edge and checks
  // content, spacing, pulse width and hold stability.
  logic       en_prev   = 1'b0;
  logic       done_prev = 1'b0;
  int         rise_c    = -1;
  logic [8:0] rise_bus  = '0;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (rst) begin
      en_prev   = 1'b0;
      done_prev = 1'b0;
      rise_c    = -1;
    end else begin
      if (LCD_EN && !en_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got rs=%0b data=%02h, required no write", LCD_RS, LCD_DATA);
        end else begin
          mon_e = exp_q.pop_front();
          check("byte_rs", {31'd0, LCD_RS}, {31'd0, mon_e.rs});
          check("byte_data", {24'd0, LCD_DATA}, {24'd0, mon_e.data});
          if (mon_e.gap != 0 && rise_c >= 0) check("byte_gap", cyc - rise_c, mon_e.gap);
        end
        rise_c   = cyc;
        rise_bus = {LCD_RS, LCD_DATA};
      end
      if (!LCD_EN && en_prev) begin
        check("en_width", cyc - rise_c, P_EN);
        check("bus_stable", {23'd0, LCD_RS, LCD_DATA}, {23'd0, rise_bus});
      end
      if (o_done) begin
        done_seen++;
        check("done_one_cycle", {31'd0, done_prev}, 32'd0);
      end
      en_prev   = LCD_EN;
      done_prev = o_done;
    end
  end

  task automatic wait_en(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (LCD_EN) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL wait_en: timeout, got no EN within %0d cycles, required EN", budget);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_idle: timeout, got busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic wait_done(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_done: timeout, got no done within %0d cycles, required done", budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, {24'd0, LCD_DATA}, 32'h00);
    check({tag, "_rs"},   {31'd0, LCD_RS},   32'd0);
    check({tag, "_en"},   {31'd0, LCD_EN},   32'd0);
    check({tag, "_busy"}, {31'd0, o_busy},   32'd1);
    check({tag, "_done"}, {31'd0, o_done},   32'd0);
  endtask

  initial begin
    logic [255:0] orig, s1, s2, s3;
    string txt;
    int t0, ta, at;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_rw",   {31'd0, LCD_RW},   32'd0);
    check("reset_on",   {31'd0, LCD_ON},   32'd1);
    check("reset_blon", {31'd0, LCD_BLON}, 32'd1);

    // Power-up and init with no request
    push_init();
    rst = 1'b0;
    t0  = cyc;
    wait_en(200, at);
    check("first_en_cycle", at - t0, P_PWR + P_SETUP);
    wait_idle(200);
    check("init_busy_fall", cyc - t0, INIT_END);

    // Known frame from IDLE
    txt = "Original Picture";
    for (int k = 0; k < 16; k++) orig[8*k +: 8] = txt[k];
    for (int k = 16; k < 32; k++) orig[8*k +: 8] = 8'h10;
    repeat (3) @(negedge clk);
    str = orig; upd = 1'b1; ta = cyc;
    push_frame(orig, 0); done_exp++;
    @(negedge clk);
    upd = 1'b0;
    check("accept_busy_rise", {31'd0, o_busy}, 32'd1);
    wait_done(FRAME_CYC + 20);
    check("done_latency", cyc - ta, FRAME_CYC + 1);
    check("busy_at_done", {31'd0, o_busy}, 32'd0);

    // Random frames with i_string scrambled while busy
    for (int r = 0; r < 3; r++) begin
      repeat (2 + r) @(negedge clk);
      s1 = rand256();
      str = s1; upd = 1'b1;
      push_frame(s1, 0); done_exp++;
      @(negedge clk);
      upd = 1'b0;
      for (int i = 0; i < FRAME_CYC + 20 && o_busy; i++) begin
        str = rand256();
        @(negedge clk);
      end
      check("scramble_idle", {31'd0, o_busy}, 32'd0);
    end

    // Two requests during a frame collapse into one back-to-back frame
    repeat (2) @(negedge clk);
    s1 = rand256();
    str = s1; upd = 1'b1;
    push_frame(s1, 0); done_exp++;
    @(negedge clk); upd = 1'b0;
    repeat (50) @(negedge clk);
    s2 = rand256();
    str = s2; upd = 1'b1;
    push_frame(s2, BYTE_P); done_exp++;
    @(negedge clk); upd = 1'b0;
    repeat (40) @(negedge clk);
    upd = 1'b1;
    @(negedge clk); upd = 1'b0;
    wait_done(FRAME_CYC);
    check("busy_between_frames", {31'd0, o_busy}, 32'd1);
    wait_done(FRAME_CYC + 20);
    check("busy_after_second", {31'd0, o_busy}, 32'd0);

    // Reset while EN is high, with a request held through power-up
    repeat (2) @(negedge clk);
    s1 = rand256();
    str = s1; upd = 1'b1;
    push_frame(s1, 0);
    @(negedge clk); upd = 1'b0;
    repeat (37) @(negedge clk);
    wait_en(50, at);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    s3 = rand256();
    str = s3; upd = 1'b1;
    push_init();
    push_frame(s3, BYTE_P); done_exp++;
    @(negedge clk);
    rst = 1'b0;
    t0  = cyc;
    repeat (10) @(negedge clk);
    upd = 1'b0;
    wait_done(INIT_END + FRAME_CYC + 20);
    check("pending_done_cycle", cyc - t0, INIT_END + FRAME_CYC);
    check("pending_busy_after", {31'd0, o_busy}, 32'd0);

    // Drain and totals
    repeat (20) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    check("done_count", done_seen, done_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
